// File: rtl/rx_serial_pkg.sv
// rtl/rx_serial_pkg.sv - shared types and helpers for the 7O1 serial receiver
package rx_serial_pkg;

  localparam int DATA_BITS     = 7;
  localparam int FRAME_SAMPLES = 9;

  typedef enum logic [2:0] {
    INICIAL      = 3'd0,
    ESPERA_START = 3'd1,
    CONFIRMA     = 3'd2,
    RECEBE       = 3'd3,
    ARMAZENA     = 3'd4
  } estado_t;

  // Parity bit that makes the total count of ones odd.
  function automatic logic paridade_impar(input logic [DATA_BITS-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/rx_serial_7o1_if.sv
// rtl/rx_serial_7o1_if.sv - serial line, handshake and status bundle
interface rx_serial_7o1_if;
  import rx_serial_pkg::*;

  logic                 dado_serial;
  logic                 recebe;
  logic [DATA_BITS-1:0] dados_ascii;
  logic                 pronto;
  logic                 tem_dado;
  logic                 erro_paridade;
  logic                 erro_stop;
  logic [3:0]           db_estado;

  modport master (
    output dado_serial, recebe,
    input  dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, db_estado
  );

  modport slave (
    input  dado_serial, recebe,
    output dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, db_estado
  );
endinterface

// File: rtl/rx_serial_uc.sv
// rtl/rx_serial_uc.sv - control state machine of the 7O1 receiver
module rx_serial_uc
  import rx_serial_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    linha,
  input  logic    inicio,
  input  logic    amostra,
  input  logic    meio,
  input  logic    fim_bit,
  input  logic    ultimo,
  output logic    cnt_clr,
  output logic    cnt_rld,
  output logic    bits_clr,
  output logic    bit_shift,
  output logic    armazena,
  output estado_t estado
);

  estado_t state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= INICIAL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_rld   = 1'b0;
    bits_clr  = 1'b0;
    bit_shift = 1'b0;
    armazena  = 1'b0;
    case (state_q)
      INICIAL: if (linha) state_d = ESPERA_START;
      ESPERA_START: if (inicio) begin
        state_d = CONFIRMA;
        cnt_clr = 1'b1;
      end
      CONFIRMA: if (meio) begin
        if (!amostra) begin
          state_d  = RECEBE;
          cnt_rld  = 1'b1;
          bits_clr = 1'b1;
        end else begin
          state_d = ESPERA_START;
        end
      end
      RECEBE: if (fim_bit) begin
        bit_shift = 1'b1;
        cnt_rld   = 1'b1;
        if (ultimo) state_d = ARMAZENA;
      end
      ARMAZENA: begin
        armazena = 1'b1;
        state_d  = ESPERA_START;
      end
      default: state_d = INICIAL;
    endcase
  end

  assign estado = state_q;

endmodule

// File: rtl/rx_serial_7o1.sv
// rtl/rx_serial_7o1.sv - 7O1 UART receiver datapath; RX_MAJORITY_EN selects 2-of-3 bit voting
module rx_serial_7o1
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic            clock,
  input  logic            reset,
  rx_serial_7o1_if.slave  bus
);

`ifdef RX_MAJORITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  // Reloading with OFS keeps the bit period at CLKS_PER_BIT while the decision sits at mid+OFS.
  localparam logic [CNT_W-1:0] MEIO_DEC = CNT_W'(CLKS_PER_BIT / 2 - 1 + OFS);
  localparam logic [CNT_W-1:0] BIT_DEC  = CNT_W'(CLKS_PER_BIT - 1 + OFS);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(OFS);

  logic                     sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               bits_q, bits_d;
  logic [FRAME_SAMPLES-1:0] sr_q, sr_d;
  logic [DATA_BITS-1:0]     dados_q, dados_d;
  logic                     pronto_q, pronto_d, tem_dado_q, tem_dado_d;
  logic                     erro_par_q, erro_par_d, erro_stop_q, erro_stop_d;
  logic                     amostra, cnt_clr, cnt_rld, bits_clr, bit_shift, armazena;
  estado_t                  estado;

`ifdef RX_MAJORITY_EN
  logic rx_prev2_q, rx_prev2_d;
  assign rx_prev2_d = rx_prev_q;
  assign amostra = (rx_prev2_q & rx_prev_q) | (rx_prev2_q & sync2_q) | (rx_prev_q & sync2_q);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_prev2_q <= 1'b0;
    else       rx_prev2_q <= rx_prev2_d;
  end
`else
  assign amostra = sync2_q;
`endif

  rx_serial_uc u_uc (
    .clock     (clock),
    .reset     (reset),
    .linha     (sync2_q),
    .inicio    (rx_prev_q & ~sync2_q),
    .amostra   (amostra),
    .meio      (cnt_q == MEIO_DEC),
    .fim_bit   (cnt_q == BIT_DEC),
    .ultimo    (bits_q == 4'(FRAME_SAMPLES - 1)),
    .cnt_clr   (cnt_clr),
    .cnt_rld   (cnt_rld),
    .bits_clr  (bits_clr),
    .bit_shift (bit_shift),
    .armazena  (armazena),
    .estado    (estado)
  );

  always_comb begin
    sync1_d   = bus.dado_serial;
    sync2_d   = sync1_q;
    rx_prev_d = sync2_q;
    cnt_d     = cnt_q + CNT_W'(1);
    if (cnt_clr)      cnt_d = '0;
    else if (cnt_rld) cnt_d = RELOAD;
    bits_d = bits_q;
    if (bits_clr)       bits_d = '0;
    else if (bit_shift) bits_d = bits_q + 4'd1;
    sr_d = bit_shift ? {amostra, sr_q[FRAME_SAMPLES-1:1]} : sr_q;
    // sr_q after the 9th sample: [6:0] data, [7] parity, [8] stop.
    dados_d     = dados_q;
    erro_par_d  = erro_par_q;
    erro_stop_d = erro_stop_q;
    pronto_d    = armazena;
    if (armazena) begin
      dados_d     = sr_q[DATA_BITS-1:0];
      erro_par_d  = sr_q[DATA_BITS] != paridade_impar(sr_q[DATA_BITS-1:0]);
      erro_stop_d = ~sr_q[FRAME_SAMPLES-1];
    end
    tem_dado_d = armazena ? 1'b1 : (bus.recebe ? 1'b0 : tem_dado_q);
  end

  // Synchronizer resets low so a line held low across reset keeps INICIAL waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      rx_prev_q   <= 1'b0;
      cnt_q       <= '0;
      bits_q      <= '0;
      sr_q        <= '0;
      dados_q     <= '0;
      pronto_q    <= 1'b0;
      tem_dado_q  <= 1'b0;
      erro_par_q  <= 1'b0;
      erro_stop_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      sr_q        <= sr_d;
      dados_q     <= dados_d;
      pronto_q    <= pronto_d;
      tem_dado_q  <= tem_dado_d;
      erro_par_q  <= erro_par_d;
      erro_stop_q <= erro_stop_d;
    end
  end

  assign bus.dados_ascii   = dados_q;
  assign bus.pronto        = pronto_q;
  assign bus.tem_dado      = tem_dado_q;
  assign bus.erro_paridade = erro_par_q;
  assign bus.erro_stop     = erro_stop_q;
  assign bus.db_estado     = {1'b0, estado};

endmodule

// File: doc/rx_serial_7o1.md
Name: rx_serial_7O1

Overview:
- UART receiver for 7O1 frames: 1 start bit, 7 data bits LSB first, odd parity, 1 stop bit.
- Receive-side counterpart of the 7O1 serial transmitter; pairs with it in loopback and board tests. Default rate is 115200 baud from 50 MHz.
- Delivers a parallel ASCII character with a ready/acknowledge handshake, plus parity and stop error flags.
- Exposes a state code for the hexa7seg debug display.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (434 = 115200 baud; 5208 = 9600 baud).
- CNT_W, 9, baud counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dado_serial  in  1  serial line, idles high
- recebe  in  1  one-cycle acknowledge; clears tem_dado
- dados_ascii  out  7  last received character
- pronto  out  1  one-cycle pulse when a frame completes
- tem_dado  out  1  character available; held until acknowledged
- erro_paridade  out  1  parity error on last frame
- erro_stop  out  1  stop bit sampled low on last frame
- db_estado  out  4  state code for debug display

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values: all outputs 0; db_estado = 0 (INICIAL); shift register, bit counter and baud counter cleared.
- Input synchronisation: dado_serial passes through a 2-FF synchronizer. All decisions use the synchronized signal (2-cycle delay).
- States and codes:
  - INICIAL 0: wait until the line has been high for 1 cycle, then go to ESPERA_START. This prevents false starts when reset is released mid-frame.
  - ESPERA_START 1: a synchronized low starts the baud counter from 0 and moves to CONFIRMA.
  - CONFIRMA 2: at count CLKS_PER_BIT/2 - 1, resample. Low: go to RECEBE with counter zeroed. High: glitch, return to ESPERA_START.
  - RECEBE 3: each time the counter reaches CLKS_PER_BIT-1, sample one bit. Bits are shifted in order d0..d6, parity, stop (9 samples, bit counter 0..8). After the 9th sample, go to ARMAZENA.
  - ARMAZENA 4: single cycle.
    - Load dados_ascii from the shift register.
    - erro_paridade = ~(XOR of d0..d6 and the parity bit); odd parity means the total count of ones is odd.
    - erro_stop = ~stop.
    - pronto = 1 for this cycle; tem_dado set.
    - Next state is ESPERA_START.
- Latency: pronto asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the falling start edge on the pin.
- Handshake: tem_dado stays 1 until recebe is sampled high.
  - recebe while tem_dado = 0 is ignored.
  - recebe in the same cycle as ARMAZENA: the completion wins and tem_dado stays 1.
- Overrun: a new frame completing while tem_dado = 1 overwrites dados_ascii and the error flags; tem_dado stays 1. No overrun flag.
- Error flags hold their values until the next ARMAZENA.
- Stop error: does not block the next start. If the line is still low after the stop sample, the next falling edge is not seen; the receiver waits in ESPERA_START until the line goes low again after returning high.
- Reset mid-frame: aborts immediately; the partial character is discarded.

Optional Feature:
- Macro: RX_MAJORITY_EN.
- Defined: each bit value (start confirm, data, parity, stop) is the 2-of-3 majority of samples taken at counts mid-1, mid and mid+1 of the bit period. The decision is made at mid+1.
- Undefined: a single sample at mid. Latency figures are unchanged apart from +1 cycle per decision when the macro is defined.

Decomposition:
- Shared package rx_serial_pkg holds:
  - state enum with codes 0..4;
  - DATA_BITS=7, FRAME_SAMPLES=9;
  - odd-parity function reused by the transmitter bench.
- One natural sub-module: rx_serial_uc (state machine only). The synchronizer, baud counter, bit counter and shift register stay in the top level.

Test Plan:
- All tests use CLKS_PER_BIT=8.
- Frame for 0x41 ('A'): 0, 1000001 LSB first, parity 1, stop 1 -> pronto pulse, dados_ascii=7'h41, tem_dado=1, both error flags 0.
- Frame for 0x43 with parity bit 1 (wrong) -> dados_ascii=7'h43, erro_paridade=1, erro_stop=0.
- Frame for 0x55 with stop bit 0 -> erro_stop=1. Drive the line high again, then send 0x2A -> received cleanly with erro_stop=0.
- 2-cycle low glitch on an idle line -> returns to ESPERA_START, no pronto, db_estado back to 1.
- Back-to-back 0x31, 0x32 without recebe -> dados_ascii=0x32, tem_dado=1. Then pulse recebe -> tem_dado=0.
- Assert reset during data bit 3, release with the line low, then send 0x7F -> no spurious frame, then 0x7F received.
